serial_subtractor: RTL and testbench

- Bit-serial WIDTH-bit subtractor; computes diff = a - b with a borrow-out, LSB first, one bit per clock.
- Inverse operation of the team's combinational 8-bit adder; shares the same operand width and sum/carry-style outputs.
- Used where area matters more than latency. Start/busy/done handshake for a controlling FSM or a randomized bench.

---
 rtl/serial_subtractor.sv | 115 +++++++++++
 tb/tb_serial_subtractor.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit unsigned subtractor: diff = a - b, LSB first, one bit per clock.
// Start/busy/done handshake; diff and bout hold the last completed result.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state_reg, state_next;
    logic [WIDTH-1:0]   sa_reg, sa_next;
    logic [WIDTH-1:0]   sb_reg, sb_next;
    logic [WIDTH-1:0]   res_reg, res_next;
    logic [WIDTH-1:0]   diff_reg, diff_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic               borrow_reg, borrow_next;
    logic               bout_reg, bout_next;
    logic               done_reg, done_next;

    logic               d_bit;
    logic               borrow_bit;
    logic [WIDTH-1:0]   res_shift;

    // One full-subtractor slice working on the current LSBs.
    assign d_bit      = sa_reg[0] ^ sb_reg[0] ^ borrow_reg;
    assign borrow_bit = (~sa_reg[0] & sb_reg[0]) | (~(sa_reg[0] ^ sb_reg[0]) & borrow_reg);

    // Result fills from the MSB so that after WIDTH shifts bit 0 sits at the LSB.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH - 1; gi++) begin : g_res_shift
            assign res_shift[gi] = res_reg[gi+1];
        end
    endgenerate
    assign res_shift[WIDTH-1] = d_bit;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            sa_reg     <= '0;
            sb_reg     <= '0;
            res_reg    <= '0;
            diff_reg   <= '0;
            cnt_reg    <= '0;
            borrow_reg <= 1'b0;
            bout_reg   <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            sa_reg     <= sa_next;
            sb_reg     <= sb_next;
            res_reg    <= res_next;
            diff_reg   <= diff_next;
            cnt_reg    <= cnt_next;
            borrow_reg <= borrow_next;
            bout_reg   <= bout_next;
            done_reg   <= done_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        sa_next     = sa_reg;
        sb_next     = sb_reg;
        res_next    = res_reg;
        diff_next   = diff_reg;
        cnt_next    = cnt_reg;
        borrow_next = borrow_reg;
        bout_next   = bout_reg;
        done_next   = 1'b0;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    sa_next     = a;
                    sb_next     = b;
                    borrow_next = 1'b0;
                    cnt_next    = '0;
                    state_next  = RUN;
                end
            end
            RUN: begin
                sa_next     = sa_reg >> 1;
                sb_next     = sb_reg >> 1;
                res_next    = res_shift;
                borrow_next = borrow_bit;
                cnt_next    = cnt_reg + CNT_W'(1);
                if (cnt_reg == CNT_W'(WIDTH - 1)) begin
                    diff_next  = res_shift;
                    bout_next  = borrow_bit;
                    done_next  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state_reg == RUN);
    assign done = done_reg;
    assign diff = diff_reg;
    assign bout = bout_reg;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: a cycle model pushes expected results on
// accepted starts; a monitor pops and compares them on every done pulse.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: tracks acceptance and completion timing independently of the DUT.
    logic [W:0] sb_q[$];
    int         rem = 0;
    bit         exp_done = 1'b0;
    logic [W:0] held = '0;
    int         accepts = 0;
    int         aborts = 0;
    int         dones = 0;
    bit         mon_en = 1'b0;

    always @(posedge clk) begin
        exp_done = 1'b0;
        if (!rst_n) begin
            if (rem > 0) aborts++;
            rem = 0;
            sb_q.delete();
            held = '0;
        end else if (rem == 0 && start) begin
            sb_q.push_back({1'b0, a} - {1'b0, b});
            rem = W;
            accepts++;
        end else if (rem > 0) begin
            rem--;
            if (rem == 0) exp_done = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            check("done", done, exp_done);
            check("busy", busy, rem != 0);
            if (done) begin
                dones++;
                check("sb_size", sb_q.size(), 1);
                if (sb_q.size() > 0) held = sb_q.pop_front();
                $display("[TB] op %0d: diff=%02h bout=%0b expected diff=%02h bout=%0b",
                         dones, diff, bout, held[W-1:0], held[W]);
            end
            check("result", {bout, diff}, held);
        end
    end

    task automatic wait_done(input string tag);
        int n = 0;
        while (!done && n < 4 * W) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done_seen"}, done, 1'b1);
    endtask

    task automatic op(input logic [W-1:0] x, input logic [W-1:0] y,
                      input logic [W-1:0] exp_d, input logic exp_b, input string tag);
        @(negedge clk);
        a = x;
        b = y;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_busy"}, busy, 1'b1);
        wait_done(tag);
        check({tag, "_diff"}, diff, exp_d);
        check({tag, "_bout"}, bout, exp_b);
    endtask

    initial begin
        void'($urandom(32'h5eed_1234));
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_diff", diff, 0);
        check("rst_bout", bout, 1'b0);
        mon_en = 1'b1;
        rst_n = 1'b1;

        op(8'h35, 8'h12, 8'h23, 1'b0, "basic");
        op(8'h12, 8'h35, 8'hDD, 1'b1, "borrow1");
        op(8'h00, 8'h01, 8'hFF, 1'b1, "borrow2");
        op(8'hFF, 8'hFF, 8'h00, 1'b0, "equal");

        // start during RUN must be ignored
        @(negedge clk);
        a = 8'h10; b = 8'h01; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        a = 8'hAA; b = 8'h55; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("ignore");
        check("ignore_diff", diff, 8'h0F);
        repeat (12) @(negedge clk);
        check("ignore_hold", diff, 8'h0F);

        // back-to-back with start held through the done cycle
        a = 8'h80; b = 8'h7F; start = 1'b1;
        @(negedge clk);
        wait_done("b2b1");
        check("b2b1_diff", diff, 8'h01);
        check("b2b1_bout", bout, 1'b0);
        a = 8'h05; b = 8'h09;
        @(negedge clk);
        start = 1'b0;
        a = 8'hFF; b = 8'h00;
        wait_done("b2b2");
        check("b2b2_diff", diff, 8'hFC);
        check("b2b2_bout", bout, 1'b1);

        // reset mid-operation aborts it
        @(negedge clk);
        a = 8'h50; b = 8'h20; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        check("abort_diff", diff, 0);
        check("abort_bout", bout, 1'b0);
        rst_n = 1'b1;
        op(8'h09, 8'h03, 8'h06, 1'b0, "after_rst");

        // randomized operands, scrambled inputs after acceptance, random idle gaps
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            a = W'($urandom);
            b = W'($urandom);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            a = W'($urandom);
            b = W'($urandom);
            wait_done("rand");
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (2) @(negedge clk);
        check("done_count", dones, accepts - aborts);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
